cpu_sram_arbiter: RTL and testbench
===================================

# cpu_sram_arbiter

Shares one single-port synchronous data/instruction SRAM between the fetch side and the memory-access side of the 5-stage MIPS pipeline. It accepts at most one request per cycle. Data requests have priority, with a bounded-starvation guarantee for fetch. Each issued access is tracked through a fixed-latency in-flight pipeline, so read data and write acknowledges return to the correct requester in issue order. An instruction-side flush discards fetch responses that are still in flight.

## Interface
- RD_LAT, 1, SRAM read latency in cycles (legal 1..4); also the write-acknowledge latency
- MAX_STREAK, 4, maximum consecutive data grants while a fetch request is waiting (legal 1..15)

Ports:
- clk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch read request
- inst_addr  in  32  fetch byte address
- inst_flush  in  1  discard all in-flight fetch responses; block a fetch grant this cycle
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables (only meaningful when data_wr=1)
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid, or store acknowledge
- data_rdata  out  32  load data
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address, {addr[31:2],2'b00}
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after an en cycle

## Operation
- Grant decision is combinational, made each cycle:
  - grant_inst = inst_req & !inst_flush & (!data_req | streak==MAX_STREAK).
  - grant_data = data_req & !grant_inst.
  - At most one grant per cycle.
- inst_addr_ok = grant_inst; data_addr_ok = grant_data.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - sram_wen = grant_data & data_wr ? data_wstrb : 4'b0.
  - sram_addr and sram_wdata are muxed from the granted side; both are 0 when there is no grant.
- Streak counter (4 bits):
  - Increments on grant_data while inst_req=1.
  - Clears on grant_inst, or when inst_req=0.
  - Saturates at MAX_STREAK.
- In-flight pipeline:
  - RD_LAT stages; each entry holds {valid, owner(0=inst,1=data), drop}.
  - Stage 0 is loaded from the grant. drop is set if owner=inst and inst_flush=1 in that same cycle; that cannot happen with the current grant equation and is kept for safety.
  - Entries shift one stage per cycle and never stall.
- Response at the last stage E:
  - inst_data_ok = E.valid & !E.owner & !E.drop & !inst_flush.
  - data_data_ok = E.valid & E.owner.
  - inst_rdata and data_rdata both equal sram_rdata when their ok is high, and 0 otherwise.
- Flush: inst_flush sets drop on every valid inst entry in every stage. It also gates an inst response arriving in the same cycle. Data entries are never affected.
- Stores still occupy a pipeline slot; data_data_ok pulses RD_LAT cycles after acceptance.

## Timing
- Reset: all pipeline entries invalid, streak=0. Every output is 0 during reset and in the cycle after reset deasserts unless requests are present.
- Accept-to-response latency is exactly RD_LAT cycles for both sides.
- Throughput is one access per cycle, sustained.
- Responses return in issue order; at most one ok pulse per cycle across both sides.
- Requesters hold req/addr/wdata stable until their addr_ok is sampled high. The arbiter does not register requests.
- Simultaneous inst_req and data_req with streak<MAX_STREAK: data wins, and inst waits.
- Starvation bound: with inst_req held high, fetch is granted within MAX_STREAK+1 cycles, unless inst_flush is asserted.
- inst_flush in the same cycle as an inst response suppresses that response.
- Reset mid-operation clears all in-flight entries. No ok is produced for accesses issued before reset.

## Structure
- Shared package constants: OWNER_INST=1'b0, OWNER_DATA=1'b1, in-flight entry width (3), SRAM address alignment mask.
- One sub-module, arb_inflight_pipe, holds the RD_LAT-deep shift register with flush-drop marking. Its inputs are push, owner and flush; its outputs are the head entry.
- Grant logic and the streak counter live in the top module.

## Test plan
- RD_LAT=1, inst_req alone at 0xBFC00000: sram_en=1, sram_addr=0xBFC00000 at cycle t, inst_data_ok=1 at t+1 with rdata = the SRAM word.
- Both sides request on the same cycle; data is a store at 0x00000103 with wstrb=4'b1000: data_addr_ok=1, sram_wen=4'b1000, inst_addr_ok=0; inst is granted at t+1; data_data_ok at t+RD_LAT and inst_data_ok one cycle later.
- MAX_STREAK=4, data_req and inst_req held high: data is granted for 4 cycles, inst on the 5th, then data for 4 again.
- RD_LAT=3, fetch accepted at t, inst_flush at t+1: no inst_data_ok at t+3; a data load accepted at t+2 still returns data_data_ok at t+5.
- Back-to-back alternating inst/data loads for 20 cycles, RD_LAT=2: 20 ok pulses in issue order, each with data matching its address.
- reset asserted at t+1 after a load accepted at t (RD_LAT=2): data_data_ok stays 0 through t+4 and all outputs are 0 during reset.

Source files
------------

// File: rtl/cpu_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_sram_arbiter_pkg
// Brief  : Shared owner codes, in-flight entry layout and address alignment.
// Rev    : 1.0
// ============================================================================
package cpu_sram_arbiter_pkg;

    localparam logic        OWNER_INST     = 1'b0;
    localparam logic        OWNER_DATA     = 1'b1;
    localparam int          INFLIGHT_W     = 3;
    localparam logic [31:0] SRAM_ADDR_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic valid;
        logic owner;
        logic drop;
    } inflight_t;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & SRAM_ADDR_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sram_arbiter_pipe.sv
`default_nettype none
// ============================================================================
// Module : arb_inflight_pipe
// Brief  : RD_LAT-deep never-stalling tracker of issued SRAM accesses.
// Rev    : 1.0
// ============================================================================
module arb_inflight_pipe
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic owner,
    input  logic flush,
    output logic head_valid,
    output logic head_owner,
    output logic head_drop
);

    inflight_t [RD_LAT-1:0] stage_q;
    inflight_t [RD_LAT-1:0] stage_d;

    always_comb begin
        stage_d          = stage_q;
        stage_d[0].valid = push;
        stage_d[0].owner = push ? owner : OWNER_INST;
        stage_d[0].drop  = push & (owner == OWNER_INST) & flush;
        // A flush poisons every fetch entry as it moves to the next stage.
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
            if (flush && stage_q[i-1].valid && (stage_q[i-1].owner == OWNER_INST)) begin
                stage_d[i].drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head_valid = stage_q[RD_LAT-1].valid;
    assign head_owner = stage_q[RD_LAT-1].owner;
    assign head_drop  = stage_q[RD_LAT-1].drop;

endmodule
`default_nettype wire

// File: rtl/cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cpu_sram_arbiter
// Brief  : Fetch/data arbiter for one shared SRAM with bounded fetch starvation.
// Rev    : 1.0
// ============================================================================
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_flush,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       streak_full;
    logic       grant_inst;
    logic       grant_data;
    logic       head_valid;
    logic       head_owner;
    logic       head_drop;

    // Reset gating keeps every output quiet while reset is held.
    always_comb begin
        streak_full = (streak_q == STREAK_LIMIT);
        grant_inst  = !reset & inst_req & !inst_flush & (!data_req | streak_full);
        grant_data  = !reset & data_req & !grant_inst;

        streak_d = streak_q;
        if (grant_inst || !inst_req) begin
            streak_d = 4'd0;
        end else if (grant_data && !streak_full) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst | grant_data;
        sram_wen     = (grant_data & data_wr) ? data_wstrb : 4'b0000;
        sram_addr    = 32'd0;
        sram_wdata   = 32'd0;
        if (grant_inst) begin
            sram_addr = align_addr(inst_addr);
        end else if (grant_data) begin
            sram_addr  = align_addr(data_addr);
            sram_wdata = data_wdata;
        end

        inst_data_ok = !reset & head_valid & (head_owner == OWNER_INST) & !head_drop & !inst_flush;
        data_data_ok = !reset & head_valid & (head_owner == OWNER_DATA);
        inst_rdata   = inst_data_ok ? sram_rdata : 32'd0;
        data_rdata   = data_data_ok ? sram_rdata : 32'd0;
    end

    arb_inflight_pipe #(
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .push       (sram_en),
        .owner      (grant_data),
        .flush      (inst_flush),
        .head_valid (head_valid),
        .head_owner (head_owner),
        .head_drop  (head_drop)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_sram_arbiter
// Brief  : Directed and randomized checks of cpu_sram_arbiter against a model.
// Rev    : 1.0
// ============================================================================
module tb_cpu_sram_arbiter;

    localparam int RD_LAT     = 2;
    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_flush, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata, sram_rdata;
    logic [3:0]  sram_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] pattern(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural SRAM: read-before-write, data appears RD_LAT cycles after en.
    logic [31:0] sram_mem [256];
    logic [31:0] rd_pipe  [RD_LAT];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= pattern(i);
            mem_ready <= 1'b1;
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= sram_en ? sram_mem[sram_addr[9:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    // Reference model: outstanding accesses as a queue of due-cycle records.
    typedef struct {
        int          due;
        bit          owner;
        bit          drop;
        bit          store;
        logic [31:0] data;
    } pend_t;

    pend_t       pq [$];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          streak_m = 0;
    logic        e_gi, e_gd, e_en, e_iok, e_dok, e_store;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;

    task automatic model_eval();
        {e_gi, e_gd, e_en, e_iok, e_dok, e_store} = '0;
        e_wen = '0; e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0;
        if (!reset) begin
            e_gi    = inst_req && !inst_flush && (!data_req || streak_m == MAX_STREAK);
            e_gd    = data_req && !e_gi;
            e_en    = e_gi || e_gd;
            e_wen   = (e_gd && data_wr) ? data_wstrb : 4'b0000;
            e_addr  = e_gi ? {inst_addr[31:2], 2'b00} : (e_gd ? {data_addr[31:2], 2'b00} : 32'd0);
            e_wdata = e_gd ? data_wdata : 32'd0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                e_dok   = pq[0].owner;
                e_iok   = !pq[0].owner && !pq[0].drop && !inst_flush;
                e_store = pq[0].store;
                e_ird   = e_iok ? pq[0].data : 32'd0;
                e_drd   = e_dok ? pq[0].data : 32'd0;
            end
        end
    endtask

    task automatic model_commit();
        pend_t p;
        int    idx;
        if (reset) begin
            pq.delete();
            streak_m = 0;
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) void'(pq.pop_front());
            if (inst_flush)
                for (int i = 0; i < pq.size(); i++) if (!pq[i].owner) pq[i].drop = 1'b1;
            if (e_en) begin
                idx     = e_gd ? int'(data_addr[9:2]) : int'(inst_addr[9:2]);
                p.due   = cyc + RD_LAT;
                p.owner = e_gd;
                p.drop  = 1'b0;
                p.store = e_gd && data_wr;
                p.data  = ref_mem[idx];
                pq.push_back(p);
                if (p.store)
                    for (int b = 0; b < 4; b++)
                        if (data_wstrb[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
            end
            if (!inst_req || e_gi) streak_m = 0;
            else if (e_gd && streak_m < MAX_STREAK) streak_m++;
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic step();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_flush = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (RD_LAT + 1) begin settle(); step(); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'hF;
            inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
            settle();
            checks++;
            if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_wen, sram_addr, sram_wdata, inst_rdata, data_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got en=%b wen=%b addr=%h aok=%b%b dok=%b%b required all 0",
                         sram_en, sram_wen, sram_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
            end
            step();
        end
        reset = 1'b0;
        idle_inputs();
        settle();
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_addr} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got en=%b addr=%h dok=%b%b required all 0", sram_en, sram_addr, inst_data_ok, data_data_ok);
        end
        step();
    endtask

    task automatic test_fetch();
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        settle();
        checks++;
        if ({inst_addr_ok, sram_en, sram_addr} !== {1'b1, 1'b1, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL fetch_issue got aok=%b en=%b addr=%h required 1 1 bfc00000", inst_addr_ok, sram_en, sram_addr);
        end
        step();
        idle_inputs();
        for (int k = 1; k <= RD_LAT; k++) begin
            settle();
            checks++;
            if (inst_data_ok !== (k == RD_LAT)) begin
                errors++;
                $display("FAIL fetch_latency cycle %0d got %b required %b", k, inst_data_ok, k == RD_LAT);
            end
            if (k == RD_LAT) begin
                checks++;
                if (inst_rdata !== ref_mem[0]) begin
                    errors++;
                    $display("FAIL fetch_rdata got %h required %h", inst_rdata, ref_mem[0]);
                end
            end
            step();
        end
    endtask

    task automatic test_priority();
        logic [31:0] wd;
        wd = $urandom;
        inst_req = 1; inst_addr = 32'h0000_0040;
        data_req = 1; data_wr = 1; data_wstrb = 4'b1000; data_addr = 32'h0000_0103; data_wdata = wd;
        settle();
        checks++;
        if ({data_addr_ok, inst_addr_ok, sram_wen, sram_addr, sram_wdata} !== {1'b1, 1'b0, 4'b1000, 32'h0000_0100, wd}) begin
            errors++;
            $display("FAIL prio_data_wins got dok=%b iok=%b wen=%b addr=%h wd=%h required 1 0 1000 00000100 %h",
                     data_addr_ok, inst_addr_ok, sram_wen, sram_addr, sram_wdata, wd);
        end
        step();
        data_req = 0; data_wr = 0; data_wstrb = 0;
        settle();
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL prio_inst_next got %b required 1", inst_addr_ok);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL prio_store_ack got d=%b i=%b required 1 0", data_data_ok, inst_data_ok);
        end
        step();
        settle();
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {1'b1, 1'b0, ref_mem[16]}) begin
            errors++;
            $display("FAIL prio_inst_resp got i=%b d=%b rd=%h required 1 0 %h", inst_data_ok, data_data_ok, inst_rdata, ref_mem[16]);
        end
        step();
    endtask

    task automatic test_streak();
        logic want_inst;
        for (int k = 0; k < 10; k++) begin
            inst_req = 1; inst_addr = 32'h300;
            data_req = 1; data_wr = 0; data_addr = 32'h200 + 32'(4 * k);
            want_inst = (k % (MAX_STREAK + 1)) == MAX_STREAK;
            settle();
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {want_inst, !want_inst}) begin
                errors++;
                $display("FAIL streak cycle %0d got i=%b d=%b required %b %b", k, inst_addr_ok, data_addr_ok, want_inst, !want_inst);
            end
            step();
        end
        drain();
    endtask

    task automatic test_flush();
        inst_req = 1; inst_addr = 32'h0000_0010;
        settle();
        checks++;
        if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL flush_fetch_a got %b required 1", inst_addr_ok); end
        step();
        inst_addr = 32'h0000_0020; inst_flush = 1;
        data_req = 1; data_wr = 0; data_addr = 32'h0000_0084;
        settle();
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
            errors++;
            $display("FAIL flush_blocks_grant got i=%b d=%b required 0 1", inst_addr_ok, data_addr_ok);
        end
        step();
        inst_flush = 0; data_req = 0;
        settle();
        checks++;
        if ({inst_addr_ok, inst_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL flush_drop_a got aok=%b dok=%b required 1 0", inst_addr_ok, inst_data_ok);
        end
        step();
        inst_req = 0;
        settle();
        checks++;
        if ({data_data_ok, data_rdata} !== {1'b1, ref_mem[33]}) begin
            errors++;
            $display("FAIL flush_data_survives got ok=%b rd=%h required 1 %h", data_data_ok, data_rdata, ref_mem[33]);
        end
        step();
        inst_flush = 1;
        settle();
        checks++;
        if ({inst_data_ok, inst_rdata} !== 33'd0) begin
            errors++;
            $display("FAIL flush_same_cycle got ok=%b rd=%h required 0 0", inst_data_ok, inst_rdata);
        end
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        bit          q_own [$];
        int          q_idx [$];
        int          pulses = 0;
        bit          own;
        int          idx;
        for (int k = 0; k < 20 + RD_LAT + 1; k++) begin
            idle_inputs();
            if (k < 20) begin
                if (k % 2 == 0) begin inst_req = 1; inst_addr = 32'h400 + 32'(8 * k); end
                else begin data_req = 1; data_addr = 32'h400 + 32'(8 * k); end
            end
            settle();
            if (inst_data_ok || data_data_ok) begin
                pulses++;
                checks++;
                if (q_own.size() == 0 || (inst_data_ok && data_data_ok)) begin
                    errors++;
                    $display("FAIL b2b_extra_pulse cycle %0d got i=%b d=%b required at most one expected pulse", k, inst_data_ok, data_data_ok);
                end else begin
                    own = q_own.pop_front();
                    idx = q_idx.pop_front();
                    if (data_data_ok !== own || (own ? data_rdata : inst_rdata) !== ref_mem[idx]) begin
                        errors++;
                        $display("FAIL b2b_order cycle %0d got owner=%b rd=%h required owner=%b rd=%h",
                                 k, data_data_ok, own ? data_rdata : inst_rdata, own, ref_mem[idx]);
                    end
                end
            end
            if (k < 20) begin
                q_own.push_back(k % 2 == 1);
                q_idx.push_back(int'((32'h400 + 32'(8 * k)) >> 2) & 255);
            end
            step();
        end
        checks++;
        if (pulses != 20) begin errors++; $display("FAIL b2b_count got %0d required 20", pulses); end
    endtask

    task automatic test_reset_mid();
        data_req = 1; data_wr = 0; data_addr = 32'h0000_0080;
        settle();
        checks++;
        if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_issue got %b required 1", data_addr_ok); end
        step();
        reset = 1; inst_req = 1; inst_addr = 32'h44;
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if ({sram_en, sram_wen, sram_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, data_rdata} !== '0) begin
                errors++;
                $display("FAIL rmid_quiet cycle %0d got en=%b addr=%h aok=%b%b dok=%b%b required all 0",
                         k, sram_en, sram_addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
            end
            step();
        end
        reset = 0;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            settle();
            checks++;
            if ({data_data_ok, inst_data_ok} !== 2'b00) begin
                errors++;
                $display("FAIL rmid_no_resp cycle %0d got d=%b i=%b required 0 0", k, data_data_ok, inst_data_ok);
            end
            step();
        end
    endtask

    task automatic test_random();
        bit i_pend = 0;
        bit d_pend = 0;
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1; inst_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; data_addr = $urandom; data_wr = $urandom_range(0, 1);
                data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            inst_req = i_pend; data_req = d_pend;
            inst_flush = ($urandom_range(0, 9) == 0);
            settle();
            checks++;
            if ({inst_addr_ok, data_addr_ok, sram_en} !== {e_gi, e_gd, e_en}) begin
                errors++;
                $display("FAIL rnd_grant n=%0d got i=%b d=%b en=%b required %b %b %b", n, inst_addr_ok, data_addr_ok, sram_en, e_gi, e_gd, e_en);
            end
            checks++;
            if ({sram_wen, sram_addr, sram_wdata} !== {e_wen, e_addr, e_wdata}) begin
                errors++;
                $display("FAIL rnd_sram n=%0d got wen=%b addr=%h wd=%h required %b %h %h", n, sram_wen, sram_addr, sram_wdata, e_wen, e_addr, e_wdata);
            end
            checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata} !== {e_iok, e_dok, e_ird}) begin
                errors++;
                $display("FAIL rnd_resp n=%0d got i=%b d=%b ird=%h required %b %b %h", n, inst_data_ok, data_data_ok, inst_rdata, e_iok, e_dok, e_ird);
            end
            if (!e_store) begin
                checks++;
                if (data_rdata !== e_drd) begin
                    errors++;
                    $display("FAIL rnd_drdata n=%0d got %h required %h", n, data_rdata, e_drd);
                end
            end
            if (e_gi) i_pend = 0;
            if (e_gd) d_pend = 0;
            step();
        end
        reset = 0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_streak();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
